// File: rtl/mmm_nlp_mont_red.sv
// mmm_nlp_mont_red: self-triggering modular exponentiation engine.
// Computes o_m = (i_m ^ i_e) mod i_n with left-to-right square-and-multiply.
// Every multiply is a bit-serial interleaved shift-add-reduce (IDW cycles),
// so any modulus n >= 1 is accepted; n == 0 yields 0. The engine reruns
// whenever the operand inputs differ from the last captured set.
module mmm_nlp_mont_red #(
    parameter int ODW = 256,
    parameter int IDW = 256,
    parameter int OAW = 24,
    parameter int OBW = 16
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic [IDW-1:0] i_m,
    input  logic [IDW-1:0] i_e,
    input  logic [IDW-1:0] i_n,
    output logic [ODW-1:0] o_m
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RED  = 3'd2;
    localparam logic [2:0] S_SQR  = 3'd3;
    localparam logic [2:0] S_MUL  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // Two guard bits: 2*acc + a stays below 4*n, so nothing overflows.
    localparam int AW = IDW + 2;

    // One multiplier iteration: double, reduce, conditionally add a, reduce.
    // Requires acc < n and a <= n so a single subtraction always suffices.
    function automatic logic [AW-1:0] modmul_step(input logic [AW-1:0]  acc,
                                                  input logic [IDW-1:0] a,
                                                  input logic           b,
                                                  input logic [IDW-1:0] n);
        logic [AW-1:0] t;
        logic [AW-1:0] nn;
        nn = {2'b00, n};
        t  = acc << 1;
        if (t >= nn) t = t - nn;
        if (b) begin
            t = t + {2'b00, a};
            if (t >= nn) t = t - nn;
        end
        return t;
    endfunction

    logic [2:0]     state_q, state_d;
    logic           vld_q, vld_d;
    logic [IDW-1:0] cm_q, cm_d;
    logic [IDW-1:0] ce_q, ce_d;
    logic [IDW-1:0] cn_q, cn_d;
    logic [OAW-1:0] cnt_q, cnt_d;
    logic [OBW-1:0] k_q, k_d;
    logic [ODW-1:0] om_q, om_d;
    logic [IDW-1:0] x_q, x_d;
    logic [IDW-1:0] base_q, base_d;
    logic [AW-1:0]  acc_q, acc_d;

    logic [IDW-1:0] mm_a;
    logic [IDW-1:0] mm_bvec;
    logic           mm_bit;
    logic           mm_last;
    logic           e_bit;
    logic [AW-1:0]  mm_res;

    // Select multiplier operands for the current phase and evaluate one step.
    always_comb begin
        mm_a    = base_q;
        mm_bvec = x_q;
        if (state_q == S_RED) begin
            mm_a    = IDW'(1);
            mm_bvec = cm_q;
        end else if (state_q == S_SQR) begin
            mm_a = x_q;
        end
        mm_bit  = |(mm_bvec & (IDW'(1) << cnt_q));
        e_bit   = |(ce_q & (IDW'(1) << k_q));
        mm_last = (cnt_q == '0);
        mm_res  = modmul_step(acc_q, mm_a, mm_bit, cn_q);
    end

    // Sequencer: capture, reduce base, then square/multiply per exponent bit.
    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        cm_d    = cm_q;
        ce_d    = ce_q;
        cn_d    = cn_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        om_d    = om_q;
        x_d     = x_q;
        base_d  = base_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (!vld_q || ({i_m, i_e, i_n} != {cm_q, ce_q, cn_q})) begin
                    cm_d    = i_m;
                    ce_d    = i_e;
                    cn_d    = i_n;
                    vld_d   = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                acc_d = '0;
                cnt_d = OAW'(IDW - 1);
                k_d   = OBW'(IDW - 1);
                if (cn_q == '0) begin
                    x_d     = '0;
                    state_d = S_DONE;
                end else begin
                    x_d     = (cn_q == IDW'(1)) ? '0 : IDW'(1);
                    state_d = S_RED;
                end
            end
            S_RED: begin
                acc_d = mm_res;
                cnt_d = cnt_q - OAW'(1);
                if (mm_last) begin
                    base_d  = mm_res[IDW-1:0];
                    acc_d   = '0;
                    cnt_d   = OAW'(IDW - 1);
                    state_d = S_SQR;
                end
            end
            S_SQR: begin
                acc_d = mm_res;
                cnt_d = cnt_q - OAW'(1);
                if (mm_last) begin
                    x_d     = mm_res[IDW-1:0];
                    acc_d   = '0;
                    cnt_d   = OAW'(IDW - 1);
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d = mm_res;
                cnt_d = cnt_q - OAW'(1);
                if (mm_last) begin
                    // Multiply always runs so latency is independent of e.
                    if (e_bit) x_d = mm_res[IDW-1:0];
                    acc_d = '0;
                    cnt_d = OAW'(IDW - 1);
                    if (k_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q - OBW'(1);
                        state_d = S_SQR;
                    end
                end
            end
            S_DONE: begin
                om_d           = '0;
                om_d[IDW-1:0]  = x_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control, captured operands and result register, cleared by reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b0;
            cm_q    <= '0;
            ce_q    <= '0;
            cn_q    <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            om_q    <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            cm_q    <= cm_d;
            ce_q    <= ce_d;
            cn_q    <= cn_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            om_q    <= om_d;
        end
    end

    // Working datapath registers; always initialised in LOAD before use.
    always_ff @(posedge i_clk) begin
        x_q    <= x_d;
        base_q <= base_d;
        acc_q  <= acc_d;
    end

    assign o_m = om_q;

endmodule

// File: tb/tb_mmm_nlp_mont_red.sv
// Testbench for mmm_nlp_mont_red at a reduced operand width (IDW=32) so
// every full-latency run stays short. Expected results are queued when a
// run's operands are driven and popped when the result is due.
module tb_mmm_nlp_mont_red;

    localparam int IDW = 32;
    localparam int ODW = 40;
    localparam int OAW = 24;
    localparam int OBW = 16;
    localparam int LAT = 1 + IDW + 2 * IDW * IDW + 1;

    typedef struct {
        logic [IDW-1:0] m;
        logic [IDW-1:0] e;
        logic [IDW-1:0] n;
        logic [ODW-1:0] exp;
        int             lat;
    } vec_t;

    logic           clk;
    logic           rstn;
    logic [IDW-1:0] m, e, n;
    logic [ODW-1:0] om;

    logic [ODW-1:0] sb[$];
    logic [ODW-1:0] last_exp;
    int             n_checks;
    int             n_pass;

    mmm_nlp_mont_red #(
        .ODW(ODW), .IDW(IDW), .OAW(OAW), .OBW(OBW)
    ) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .i_m   (m),
        .i_e   (e),
        .i_n   (n),
        .o_m   (om)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Right-to-left reference exponentiation using 64-bit products.
    function automatic logic [IDW-1:0] ref_modexp(input logic [IDW-1:0] bm,
                                                  input logic [IDW-1:0] be,
                                                  input logic [IDW-1:0] bn);
        logic [63:0] r, b, nn;
        if (bn == '0) return '0;
        nn = 64'(bn);
        r  = 64'd1 % nn;
        b  = 64'(bm) % nn;
        for (int i = 0; i < IDW; i++) begin
            if (be[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[IDW-1:0];
    endfunction

    task automatic tick(input int cnt);
        repeat (cnt) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [IDW-1:0] mv, input logic [IDW-1:0] ev,
                         input logic [IDW-1:0] nv, input logic [ODW-1:0] expv);
        m = mv;
        e = ev;
        n = nv;
        sb.push_back(expv);
    endtask

    function automatic logic [ODW-1:0] pop_exp();
        if (sb.size() == 0) return '1;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        logic [ODW-1:0] expv;
        rstn = 1'b0;
        drive(32'd3, 32'd5, 32'd7, 40'd5);
        tick(3);
        expv = '0;
        n_checks++;
        if (om !== expv) $display("FAIL reset_o_m: got %h want %h", om, expv);
        else n_pass++;
        #4 rstn = 1'b1;
    endtask

    task automatic test_basic();
        logic [ODW-1:0] expv;
        tick(LAT);
        n_checks++;
        if (om !== last_exp) $display("FAIL basic_hold_pre: got %h want %h", om, last_exp);
        else n_pass++;
        tick(1);
        expv = pop_exp();
        n_checks++;
        if (om !== expv) $display("FAIL basic_result: got %h want %h", om, expv);
        else n_pass++;
        last_exp = expv;
        tick(7);
        n_checks++;
        if (om !== expv) $display("FAIL basic_hold_post: got %h want %h", om, expv);
        else n_pass++;
    endtask

    task automatic test_vectors();
        vec_t vecs[8];
        logic [ODW-1:0] expv;
        vecs[0] = '{32'd9,          32'd3, 32'd7,          40'd1,     LAT};
        vecs[1] = '{32'd10,         32'd3, 32'h0004_0000,  40'h3E8,   LAT};
        vecs[2] = '{32'h80A1,       32'd0, 32'h0004_0000,  40'd1,     LAT};
        vecs[3] = '{32'd5,          32'd3, 32'd0,          40'd0,     2};
        vecs[4] = '{32'd5,          32'd7, 32'd1,          40'd0,     LAT};
        vecs[5] = '{32'hFFFF_FFFF,  32'd2, 32'hFFFF_FFFF,  40'd0,     LAT};
        vecs[6] = '{32'hFFFF_FFFE,  32'd2, 32'hFFFF_FFFF,  40'd1,     LAT};
        vecs[7] = '{32'd0,          32'd9, 32'd13,         40'd0,     LAT};
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].m, vecs[i].e, vecs[i].n, vecs[i].exp);
            tick(vecs[i].lat);
            n_checks++;
            if (om !== last_exp) $display("FAIL vec%0d_hold_pre: got %h want %h", i, om, last_exp);
            else n_pass++;
            tick(1);
            expv = pop_exp();
            n_checks++;
            if (om !== expv) $display("FAIL vec%0d_result: got %h want %h", i, om, expv);
            else n_pass++;
            last_exp = expv;
            tick(2);
        end
    endtask

    task automatic test_back_to_back();
        logic [ODW-1:0] expv;
        drive(32'd3, 32'd5, 32'd7, 40'd5);
        tick(100);
        drive(32'd2, 32'd10, 32'd1000, 40'd24);
        tick(LAT - 100);
        n_checks++;
        if (om !== last_exp) $display("FAIL b2b_hold_pre: got %h want %h", om, last_exp);
        else n_pass++;
        tick(1);
        expv = pop_exp();
        n_checks++;
        if (om !== expv) $display("FAIL b2b_first: got %h want %h", om, expv);
        else n_pass++;
        last_exp = expv;
        tick(LAT);
        n_checks++;
        if (om !== last_exp) $display("FAIL b2b_hold_mid: got %h want %h", om, last_exp);
        else n_pass++;
        tick(1);
        expv = pop_exp();
        n_checks++;
        if (om !== expv) $display("FAIL b2b_second: got %h want %h", om, expv);
        else n_pass++;
        last_exp = expv;
        tick(2);
    endtask

    task automatic test_async_reset();
        logic [ODW-1:0] expv;
        drive(32'd4, 32'd13, 32'd497, 40'd445);
        tick(300);
        #2 rstn = 1'b0;
        #1;
        expv = '0;
        n_checks++;
        if (om !== expv) $display("FAIL areset_o_m: got %h want %h", om, expv);
        else n_pass++;
        last_exp = expv;
        tick(2);
        #4 rstn = 1'b1;
        tick(LAT);
        n_checks++;
        if (om !== last_exp) $display("FAIL areset_hold_pre: got %h want %h", om, last_exp);
        else n_pass++;
        tick(1);
        expv = pop_exp();
        n_checks++;
        if (om !== expv) $display("FAIL areset_result: got %h want %h", om, expv);
        else n_pass++;
        last_exp = expv;
        tick(2);
    endtask

    task automatic test_random();
        logic [IDW-1:0] mv, ev, nv;
        logic [ODW-1:0] expv;
        for (int i = 0; i < 3; i++) begin
            mv = $urandom;
            ev = $urandom;
            nv = $urandom;
            if (nv == '0) nv = 32'd12345;
            drive(mv, ev, nv, ODW'(ref_modexp(mv, ev, nv)));
            tick(LAT);
            n_checks++;
            if (om !== last_exp) $display("FAIL rand%0d_hold_pre: got %h want %h", i, om, last_exp);
            else n_pass++;
            tick(1);
            expv = pop_exp();
            n_checks++;
            if (om !== expv)
                $display("FAIL rand%0d_result: m=%h e=%h n=%h got %h want %h", i, mv, ev, nv, om, expv);
            else n_pass++;
            last_exp = expv;
            tick(2);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        last_exp = '0;
        rstn     = 1'b0;
        m        = '0;
        e        = '0;
        n        = '0;
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmm_nlp_mont_red.md
# mmm_nlp_mont_red

Sequential modular-exponentiation engine computing o_m = (i_m ^ i_e) mod i_n on IDW-bit operands. It uses left-to-right square-and-multiply over a bit-serial interleaved (shift-add-reduce) modular multiplier, so any modulus n ≥ 1 is supported, odd or even. It is a self-triggering leaf block in the mmm_nlp datapath with no handshake ports. It recomputes whenever its operand inputs change and holds the last result on o_m.

## Interface
- ODW, 256: result width; must be ≥ IDW; result zero-extended into o_m.
- IDW, 256: operand width of m, e, n.
- OAW, 24: width of the intra-multiply iteration counter; must be ≥ clog2(IDW)+1.
- OBW, 16: width of the exponent-bit index counter; must be ≥ clog2(IDW)+1.

Ports:
- i_clk  in  1  single clock, all state on rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_m  in  IDW  base.
- i_e  in  IDW  exponent.
- i_n  in  IDW  modulus.
- o_m  out  ODW  registered result (m^e) mod n.

## Operation
- Captured registers: cm, ce, cn (IDW each), plus flag vld (captured set valid). Reset clears all of them; o_m resets to 0.
- Core modmul(a, b) computes (a·b) mod cn, with a < cn:
  - acc = 0.
  - For each bit of b, MSB first, one cycle per bit: acc = 2·acc, subtract cn if ≥ cn; then if the bit is 1, acc = acc + a, subtract cn if ≥ cn.
  - Internal width is IDW+2 bits, so there is no overflow.
  - Takes exactly IDW cycles.
- States:
  - IDLE: if vld=0, or {i_m,i_e,i_n} ≠ {cm,ce,cn}, capture the inputs, set vld=1, go to LOAD.
  - LOAD (1 cycle): if cn==0 go to DONE with result 0. Otherwise set x = 1 mod cn (0 if cn==1), bit index k = IDW-1, go to RED.
  - RED (IDW cycles): base = modmul(1, cm) = cm mod cn, which handles m ≥ n. Then go to SQR.
  - SQR (IDW cycles): t = modmul(x, x); x = t. Then go to MUL.
  - MUL (IDW cycles): t = modmul(base, x), always executed for constant latency. x = t only if ce[k]==1. If k==0 go to DONE; else k = k-1 and go to SQR.
  - DONE (1 cycle): o_m = zero-extended x (or 0 when cn==0). Go to IDLE.
- Input changes during LOAD..DONE are ignored. They are detected in IDLE on the next pass, which triggers a new run.
- Edge results:
  - e == 0 → 1 mod n.
  - n == 1 → 0.
  - m == 0 with e ≠ 0 → 0.
  - n == 0 → 0 by definition.

## Timing
- Latency from capture (IDLE edge) to o_m update:
  - n ≠ 0: 1 + IDW + 2·IDW·IDW + 1 cycles. With IDW=256 this is 131330 cycles.
  - n == 0: 2 cycles.
- o_m changes only on the DONE edge and holds between runs. The first run starts on the first clock after reset release, computing from whatever inputs are present (X inputs give an undefined result).
- Asynchronous reset at any time:
  - o_m = 0 and state = IDLE immediately.
  - vld = 0, so a fresh computation starts after release.
- Back-to-back: if the inputs changed during a run, IDLE captures them 1 cycle after DONE.

## Test plan
- m=3, e=5, n=7 → o_m=5 exactly 1+IDW+2·IDW²+1 cycles after capture; o_m held afterwards.
- m=9, e=3, n=7 (m ≥ n) → o_m=1. m=10, e=3, n=0x40000 (even modulus) → o_m=0x3E8.
- m=0x80A1, e=0, n=0x40000 → o_m=1. m=5, e=7, n=1 → o_m=0. n=0 → o_m=0 after 2 cycles.
- m=2^IDW−1, e=2, n=2^IDW−1 → o_m=0. m=2^IDW−2, e=2, n=2^IDW−1 → o_m=1 (full-width carry path).
- Change inputs mid-run from (3,5,7) to (2,10,1000): first result 5 is still produced, then the new run gives o_m=24.
- Assert i_rstn low mid-run → o_m=0 asynchronously. Release → recompute the current inputs, result correct after full latency.
